// File: rtl/pc_unit.sv
// pc_unit: program counter with stall, sticky halt and a circular
// return-address stack used to predict the target of returns.
// The PC and RAS advance only on an enabled, non-halted, non-halting edge.
module pc_unit #(
    parameter int               WIDTH     = 32,
    parameter logic [WIDTH-1:0] RESET_PC  = '0,
    parameter int               RAS_DEPTH = 4
) (
    input  logic                       CLK,
    input  logic                       RST,
    input  logic                       en,
    input  logic                       halt,
    input  logic                       jump,
    input  logic [25:0]                jumpi_addr,
    input  logic                       branch,
    input  logic [15:0]                branch_addr,
    input  logic                       jr,
    input  logic [WIDTH-1:0]           jr_addr,
    input  logic                       link,
    input  logic                       ret,
    output logic [WIDTH-1:0]           addr,
    output logic [WIDTH-1:0]           npc,
    output logic                       halted,
    output logic [$clog2(RAS_DEPTH):0] ras_count,
    output logic                       ras_miss
);

    localparam int PTR_W = $clog2(RAS_DEPTH);
    localparam int CNT_W = PTR_W + 1;
    localparam logic [CNT_W-1:0] RAS_FULL = CNT_W'(RAS_DEPTH);

    // Elaboration-time parameter sanity checks.
    if (WIDTH < 32) begin : g_bad_width
        $error("pc_unit: WIDTH must be >= 32");
    end
    if (RESET_PC[1:0] != 2'b00) begin : g_bad_reset_pc
        $error("pc_unit: RESET_PC must be word aligned");
    end
    if ((RAS_DEPTH < 2) || ((RAS_DEPTH & (RAS_DEPTH - 1)) != 0)) begin : g_bad_depth
        $error("pc_unit: RAS_DEPTH must be a power of two >= 2");
    end

    // Next-address source, highest priority first in the selection logic.
    typedef enum logic [2:0] {
        SRC_SEQ,
        SRC_BR,
        SRC_JMP,
        SRC_JR,
        SRC_RET
    } src_e;

    // Jump-immediate target: keep the top region bits of pc+4.
    function automatic logic [WIDTH-1:0] jump_target(
        input logic [WIDTH-1:0] base,
        input logic [25:0]      field
    );
        return {base[WIDTH-1:28], field, 2'b00};
    endfunction

    // Branch target: pc+4 plus the sign-extended word offset, modulo 2^WIDTH.
    function automatic logic [WIDTH-1:0] branch_target(
        input logic [WIDTH-1:0]   base,
        input logic signed [15:0] offset
    );
        logic signed [WIDTH-1:0] off_ext;
        off_ext = offset;
        return base + $unsigned(off_ext <<< 2);
    endfunction

    // Architectural state.
    logic [WIDTH-1:0] pc_p0;
    logic             halted_p0;
    logic             ras_miss_p0;
    logic [PTR_W-1:0] ras_ptr_p0;
    logic [CNT_W-1:0] ras_cnt_p0;
    logic [WIDTH-1:0] ras_mem [RAS_DEPTH];

    // Next-state and helper signals.
    logic [WIDTH-1:0] pc4;
    logic [WIDTH-1:0] pc_nxt;
    logic             halted_nxt;
    logic             ras_miss_nxt;
    logic [PTR_W-1:0] ras_ptr_nxt;
    logic [CNT_W-1:0] ras_cnt_nxt;
    logic [PTR_W-1:0] ras_top_idx;
    logic [WIDTH-1:0] ras_top;
    logic             ras_empty;
    logic             ras_full;
    logic             take;
    logic             do_push;
    logic             do_pop;
    logic             do_replace;
    logic             ras_we;
    logic [PTR_W-1:0] ras_widx;
    src_e             src;

    assign pc4         = pc_p0 + WIDTH'(4);
    assign ras_top_idx = ras_ptr_p0 - PTR_W'(1);
    assign ras_top     = ras_mem[ras_top_idx];
    assign ras_empty   = (ras_cnt_p0 == '0);
    assign ras_full    = (ras_cnt_p0 == RAS_FULL);

    // An edge that samples halt must not advance, so halt blocks it immediately.
    assign take       = en && !halted_p0 && !halt;
    assign halted_nxt = halted_p0 | halt;

    // Priority select among the redirect strobes.
    always_comb begin
        src = SRC_SEQ;
        if (ret) begin
            src = SRC_RET;
        end else if (jr) begin
            src = SRC_JR;
        end else if (jump) begin
            src = SRC_JMP;
        end else if (branch) begin
            src = SRC_BR;
        end
    end

    // Next PC and the RAS operation requested by the selected source.
    always_comb begin
        pc_nxt       = pc_p0;
        do_push      = 1'b0;
        do_pop       = 1'b0;
        do_replace   = 1'b0;
        ras_miss_nxt = 1'b0;
        if (take) begin
            case (src)
                SRC_RET: begin
                    if (!ras_empty) begin
                        pc_nxt = ras_top;
                        // ret with link is pop-then-push: overwrite the top in place.
                        if (link) begin
                            do_replace = 1'b1;
                        end else begin
                            do_pop = 1'b1;
                        end
                    end else begin
                        pc_nxt       = jr_addr;
                        ras_miss_nxt = 1'b1;
                        do_push      = link;
                    end
                end
                SRC_JR: begin
                    pc_nxt  = jr_addr;
                    do_push = link;
                end
                SRC_JMP: begin
                    pc_nxt  = jump_target(pc4, jumpi_addr);
                    do_push = link;
                end
                SRC_BR: begin
                    pc_nxt = branch_target(pc4, $signed(branch_addr));
                end
                default: begin
                    pc_nxt = pc4;
                end
            endcase
        end
    end

    // RAS pointer/count bookkeeping; a push when full overwrites the oldest slot.
    always_comb begin
        ras_ptr_nxt = ras_ptr_p0;
        ras_cnt_nxt = ras_cnt_p0;
        ras_we      = 1'b0;
        ras_widx    = ras_ptr_p0;
        if (do_push) begin
            ras_we      = 1'b1;
            ras_widx    = ras_ptr_p0;
            ras_ptr_nxt = ras_ptr_p0 + PTR_W'(1);
            if (!ras_full) begin
                ras_cnt_nxt = ras_cnt_p0 + CNT_W'(1);
            end
        end else if (do_replace) begin
            ras_we   = 1'b1;
            ras_widx = ras_top_idx;
        end else if (do_pop) begin
            ras_ptr_nxt = ras_top_idx;
            ras_cnt_nxt = ras_cnt_p0 - CNT_W'(1);
        end
    end

    // Control state register: reset dominates everything.
    always_ff @(posedge CLK) begin
        if (RST) begin
            pc_p0       <= RESET_PC;
            halted_p0   <= 1'b0;
            ras_miss_p0 <= 1'b0;
            ras_ptr_p0  <= '0;
            ras_cnt_p0  <= '0;
        end else begin
            pc_p0       <= pc_nxt;
            halted_p0   <= halted_nxt;
            ras_miss_p0 <= ras_miss_nxt;
            ras_ptr_p0  <= ras_ptr_nxt;
            ras_cnt_p0  <= ras_cnt_nxt;
        end
    end

    // RAS storage: contents are not reset, only the pointer and count are.
    always_ff @(posedge CLK) begin
        if (!RST && ras_we) begin
            ras_mem[ras_widx] <= pc4;
        end
    end

    assign addr      = pc_p0;
    assign npc       = pc4;
    assign halted    = halted_p0;
    assign ras_count = ras_cnt_p0;
    assign ras_miss  = ras_miss_p0;

endmodule

// File: tb/tb_pc_unit.sv
// Testbench for pc_unit: directed walk through the main scenarios followed by
// randomized traffic, all checked against a queue-based reference model.
module tb_pc_unit;

    localparam int          WIDTH     = 32;
    localparam int          RAS_DEPTH = 4;
    localparam logic [31:0] RESET_PC  = 32'h0;

    logic        CLK;
    logic        RST;
    logic        en;
    logic        halt;
    logic        jump;
    logic [25:0] jumpi_addr;
    logic        branch;
    logic [15:0] branch_addr;
    logic        jr;
    logic [31:0] jr_addr;
    logic        link;
    logic        ret;
    logic [31:0] addr;
    logic [31:0] npc;
    logic        halted;
    logic [2:0]  ras_count;
    logic        ras_miss;

    pc_unit #(
        .WIDTH    (WIDTH),
        .RESET_PC (RESET_PC),
        .RAS_DEPTH(RAS_DEPTH)
    ) dut (
        .CLK        (CLK),
        .RST        (RST),
        .en         (en),
        .halt       (halt),
        .jump       (jump),
        .jumpi_addr (jumpi_addr),
        .branch     (branch),
        .branch_addr(branch_addr),
        .jr         (jr),
        .jr_addr    (jr_addr),
        .link       (link),
        .ret        (ret),
        .addr       (addr),
        .npc        (npc),
        .halted     (halted),
        .ras_count  (ras_count),
        .ras_miss   (ras_miss)
    );

    initial begin
        CLK = 1'b0;
        forever #5 CLK = ~CLK;
    end

    int total  = 0;
    int passed = 0;
    int failed = 0;

    // Reference model: PC value, flags, and the RAS as a bounded stack.
    logic [31:0] m_pc     = 32'h0;
    bit          m_halted = 1'b0;
    bit          m_miss   = 1'b0;
    logic [31:0] m_stack[$];

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        total++;
        assert (obs === exp) passed++;
        else begin
            failed++;
            $error("FAIL %s: observed 0x%0h, expected 0x%0h", tag, obs, exp);
        end
    endtask

    task automatic m_push(input logic [31:0] v);
        m_stack.push_back(v);
        if (m_stack.size() > RAS_DEPTH) begin
            void'(m_stack.pop_front());
        end
    endtask

    // Advance the model by one clock edge using the currently driven inputs.
    task automatic model_edge();
        logic [31:0]        pc4;
        logic signed [31:0] off;
        if (RST) begin
            m_pc     = RESET_PC;
            m_halted = 1'b0;
            m_miss   = 1'b0;
            m_stack.delete();
        end else begin
            m_miss = 1'b0;
            if (en && !m_halted && !halt) begin
                pc4 = m_pc + 32'd4;
                if (ret) begin
                    if (m_stack.size() > 0) begin
                        m_pc = m_stack.pop_back();
                    end else begin
                        m_pc   = jr_addr;
                        m_miss = 1'b1;
                    end
                    if (link) m_push(pc4);
                end else if (jr) begin
                    m_pc = jr_addr;
                    if (link) m_push(pc4);
                end else if (jump) begin
                    m_pc = (pc4 & 32'hF000_0000) | (32'(jumpi_addr) << 2);
                    if (link) m_push(pc4);
                end else if (branch) begin
                    off  = $signed(branch_addr);
                    m_pc = pc4 + off * 4;
                end else begin
                    m_pc = pc4;
                end
            end
            if (halt) m_halted = 1'b1;
        end
    endtask

    // One clock: update model, wait past the edge, compare every output.
    task automatic step();
        model_edge();
        @(posedge CLK);
        #1;
        chk("model_addr", addr, m_pc);
        chk("model_npc", npc, m_pc + 32'd4);
        chk("model_halted", 32'(halted), 32'(m_halted));
        chk("model_ras_count", 32'(ras_count), 32'(m_stack.size()));
        chk("model_ras_miss", 32'(ras_miss), 32'(m_miss));
    endtask

    initial begin
        logic [31:0] exp_ret [4];
        exp_ret = '{32'h44, 32'h34, 32'h24, 32'h14};

        RST = 1'b1; en = 1'b0; halt = 1'b0; jump = 1'b0; jumpi_addr = '0;
        branch = 1'b0; branch_addr = '0; jr = 1'b0; jr_addr = '0; link = 1'b0; ret = 1'b0;

        // Reset for two cycles
        step();
        step();
        chk("rst_addr", addr, RESET_PC);
        chk("rst_halted", 32'(halted), 0);
        chk("rst_ras_count", 32'(ras_count), 0);
        chk("rst_ras_miss", 32'(ras_miss), 0);

        // Sequential fetch
        RST = 1'b0; en = 1'b1;
        step(); chk("seq_addr_4", addr, 32'h4);
        step(); chk("seq_addr_8", addr, 32'h8);
        step(); chk("seq_addr_c", addr, 32'hC);
        chk("seq_npc", npc, 32'h10);

        // Branch and jump
        jump = 1'b1; jumpi_addr = 26'h40;
        step(); chk("jump_to_100", addr, 32'h100);
        jump = 1'b0; branch = 1'b1; branch_addr = 16'hFFFE;
        step(); chk("branch_back", addr, 32'hFC);
        branch = 1'b0; jump = 1'b1; jumpi_addr = 26'h40;
        step(); chk("jump_again", addr, 32'h100);
        branch = 1'b1; branch_addr = 16'h0010; jumpi_addr = 26'h80;
        step(); chk("jump_over_branch", addr, 32'h200);

        // Call and return
        branch = 1'b0; link = 1'b1; jumpi_addr = 26'h100;
        step(); chk("call_addr", addr, 32'h400);
        chk("call_count", 32'(ras_count), 1);
        jump = 1'b0; link = 1'b0; ret = 1'b1;
        step(); chk("ret_addr", addr, 32'h204);
        chk("ret_count", 32'(ras_count), 0);
        chk("ret_miss", 32'(ras_miss), 0);

        // RAS overflow: five linked jumps from 0x0 .. 0x40
        ret = 1'b0; jump = 1'b1; jumpi_addr = 26'h0;
        step(); chk("goto_zero", addr, 32'h0);
        link = 1'b1;
        for (int i = 0; i < 5; i++) begin
            jumpi_addr = 26'((i + 1) * 4);
            step();
        end
        chk("ovf_count", 32'(ras_count), 4);
        chk("ovf_addr", addr, 32'h50);

        // RAS underflow: four hits then one miss
        jump = 1'b0; link = 1'b0; ret = 1'b1; jr_addr = 32'hDEAD0;
        for (int i = 0; i < 4; i++) begin
            step();
            chk("pop_addr", addr, exp_ret[i]);
            chk("pop_no_miss", 32'(ras_miss), 0);
        end
        step();
        chk("underflow_addr", addr, 32'hDEAD0);
        chk("underflow_miss", 32'(ras_miss), 1);
        chk("underflow_count", 32'(ras_count), 0);
        ret = 1'b0;
        step();
        chk("miss_one_cycle", 32'(ras_miss), 0);
        chk("after_miss_addr", addr, 32'hDEAD4);

        // Stall with a pending branch
        en = 1'b0; branch = 1'b1; branch_addr = 16'h0100;
        for (int i = 0; i < 3; i++) begin
            step();
            chk("stall_addr", addr, 32'hDEAD4);
        end

        // Linked jump to 0x80, then halt
        branch = 1'b0; en = 1'b1; jump = 1'b1; link = 1'b1; jumpi_addr = 26'h20;
        step(); chk("goto_80", addr, 32'h80);
        chk("pre_halt_count", 32'(ras_count), 1);
        link = 1'b0; halt = 1'b1; jumpi_addr = 26'h3FF;
        step();
        chk("halt_addr", addr, 32'h80);
        chk("halt_flag", 32'(halted), 1);
        halt = 1'b0; ret = 1'b1;
        for (int i = 0; i < 3; i++) begin
            en = (i != 1);
            step();
            chk("halted_addr", addr, 32'h80);
            chk("halted_sticky", 32'(halted), 1);
            chk("halted_count", 32'(ras_count), 1);
        end

        // Reset during a linked jump discards the RAS
        en = 1'b1; RST = 1'b1; ret = 1'b0; jump = 1'b1; link = 1'b1;
        step();
        chk("midrst_addr", addr, RESET_PC);
        chk("midrst_count", 32'(ras_count), 0);
        chk("midrst_halted", 32'(halted), 0);
        RST = 1'b0; jump = 1'b0; link = 1'b0; ret = 1'b1; jr_addr = 32'h1234_5670;
        step();
        chk("midrst_ret_miss", 32'(ras_miss), 1);
        chk("midrst_ret_addr", addr, 32'h1234_5670);

        // Randomized traffic
        for (int n = 0; n < 500; n++) begin
            RST         = ($urandom_range(0, 49) == 0);
            halt        = ($urandom_range(0, 79) == 0);
            en          = ($urandom_range(0, 9) != 0);
            ret         = ($urandom_range(0, 4) == 0);
            jr          = ($urandom_range(0, 5) == 0);
            jump        = ($urandom_range(0, 3) == 0);
            branch      = ($urandom_range(0, 2) == 0);
            link        = ($urandom_range(0, 1) == 0);
            jumpi_addr  = 26'($urandom);
            branch_addr = 16'($urandom);
            jr_addr     = $urandom;
            step();
        end

        $display("%0d/%0d checks passed", passed, total);
        $finish;
    end

endmodule
